vrased_reset_ctrl: RTL
======================

# vrased_reset_ctrl

Responder to the VRASED monitor's `reset` output. It turns a violation request into a controlled recovery sequence for the MSP430 core:
- hold the CPU in reset;
- wipe data RAM word by word while driving `clr_ram` back to the monitor;
- release the core.

It sits between `vrased` and the core/RAM reset and write ports. It also runs the same sequence once after power-on.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: consecutive violation-free cycles required before clearing starts (≥1).
- `CLR_CYCLES`, default 256: number of RAM words cleared (1..2**RAM_AW).
- `RAM_AW`, default 8: RAM clear address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `viol_i`  in  1  violation request from `vrased` `reset`; synchronous to `clk`, level.
- `cpu_rst`  out  1  active-high core reset.
- `clr_ram`  out  1  RAM-clear in progress; drives `vrased` `clr_ram`.
- `ram_clr_we`  out  1  RAM write strobe during clearing.
- `ram_clr_addr`  out  RAM_AW  word address being cleared.
- `ram_clr_data`  out  16  constant 16'h0000.
- `busy`  out  1  high whenever state ≠ IDLE.
- `viol_cnt`  out  8  saturating count of violation rising edges.

## Operation
- FSM states: HOLD, CLEAR, RELEASE, IDLE. Internal counter `cnt` is 16 bits. `viol_q` is the registered `viol_i` for edge detection.
- All outputs are registered or decoded from the state register (Moore). There is no combinational path from `viol_i` to any output.
- HOLD:
  - `cpu_rst`=1, `clr_ram`=0, `ram_clr_we`=0.
  - `viol_i`=1 forces `cnt`←0.
  - Otherwise `cnt` increments.
  - When `viol_i`=0 and `cnt`==HOLD_CYCLES-1: go to CLEAR with `cnt`←0.
- CLEAR:
  - `cpu_rst`=1, `clr_ram`=1, `ram_clr_we`=1, `ram_clr_addr`=`cnt[RAM_AW-1:0]`.
  - `cnt` increments each cycle.
  - When `cnt`==CLR_CYCLES-1: go to RELEASE.
  - `viol_i`=1 aborts to HOLD with `cnt`←0. The full clear restarts later from address 0.
- RELEASE:
  - `cpu_rst`=1, `clr_ram`=0, `ram_clr_we`=0. Lasts one cycle, then IDLE.
  - `viol_i`=1 goes to HOLD with `cnt`←0.
- IDLE:
  - `cpu_rst`=0; all strobes 0.
  - `viol_i`=1 goes to HOLD with `cnt`←0.
- `ram_clr_addr`=0 outside CLEAR. `ram_clr_data` is always 0.
- `viol_cnt` increments when `viol_i`=1 and `viol_q`=0, in any state. It saturates at 8'hFF and never wraps.
- Power-on clear is not counted.

## Timing
- Reset (`reset_n`=0, asynchronous) sets:
  - state=HOLD, `cnt`=0, `viol_q`=0, `viol_cnt`=0;
  - `cpu_rst`=1, `busy`=1, `clr_ram`=0, `ram_clr_we`=0, `ram_clr_addr`=0.
- After `reset_n` deasserts with `viol_i`=0:
  - CLEAR begins at the HOLD_CYCLES-th rising edge.
  - CLEAR lasts CLR_CYCLES cycles.
  - RELEASE lasts 1 cycle.
  - `cpu_rst` falls after edge HOLD_CYCLES+CLR_CYCLES+1. With defaults that is edge 261.
- Violation latency: `viol_i`=1 sampled at edge N gives `cpu_rst`=1 and `busy`=1 after edge N.
- For a one-cycle pulse at edge N:
  - CLEAR entered at edge N+HOLD_CYCLES;
  - IDLE entered at edge N+HOLD_CYCLES+CLR_CYCLES+1.
- Held `viol_i` keeps the FSM in HOLD indefinitely. Counting starts on the first edge with `viol_i`=0.
- Writes are one per cycle with no stalls. Addresses are strictly ascending 0..CLR_CYCLES-1 within one uninterrupted CLEAR.
- Violation on the last CLEAR cycle (`cnt`==CLR_CYCLES-1): abort to HOLD takes priority over RELEASE.
- `reset_n` asserted mid-sequence returns to HOLD immediately and clears `viol_cnt`.

## Test plan
Bench parameters: HOLD_CYCLES=4, CLR_CYCLES=16, RAM_AW=4.
- Power-on:
  - stimulus: `reset_n` low 2 cycles, then high, `viol_i`=0;
  - response: `cpu_rst`=1 through edge 20 and 0 after edge 21; `ram_clr_we` high exactly 16 cycles with addresses 0..15; `viol_cnt`=0.
- Single pulse in IDLE:
  - stimulus: `viol_i`=1 for one cycle at edge N;
  - response: `cpu_rst`=1 after N; first write (addr 0) in the cycle after N+4; IDLE after N+21; `viol_cnt`=1.
- Held violation:
  - stimulus: `viol_i`=1 for 10 cycles;
  - response: HOLD throughout with no writes; CLEAR starts 4 edges after `viol_i` falls; `viol_cnt` increments once.
- Abort mid-clear:
  - stimulus: pulse `viol_i` while `ram_clr_addr`=7;
  - response: `ram_clr_we` drops next cycle; after 4 quiet cycles clearing restarts at addr 0 and completes all 16; `viol_cnt`=2.
- Edge cases:
  - stimulus: pulse on the addr=15 cycle → required response: no RELEASE, HOLD entered instead;
  - stimulus: pulse during RELEASE → required response: HOLD entered instead of IDLE.
- Saturation and async reset:
  - stimulus: 300 separated pulses → required response: `viol_cnt`=8'hFF with no wrap;
  - stimulus: assert `reset_n`=0 mid-CLEAR → required response: outputs immediately at reset values.

Source files
------------

// File: rtl/vrased_reset_ctrl.sv
// vrased_reset_ctrl: recovery sequencer driven by the VRASED monitor's reset
// request. It holds the MSP430 core in reset and waits for the violation to
// clear. It then wipes data RAM one word per cycle while flagging clr_ram
// back to the monitor, and finally releases the core. The same sequence runs
// once after power-on because the reset state is HOLD.
module vrased_reset_ctrl #(
   parameter int HOLD_CYCLES = 4,
   parameter int CLR_CYCLES  = 256,
   parameter int RAM_AW      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              viol_i,
   output logic              cpu_rst,
   output logic              clr_ram,
   output logic              ram_clr_we,
   output logic [RAM_AW-1:0] ram_clr_addr,
   output logic [15:0]       ram_clr_data,
   output logic              busy,
   output logic [7:0]        viol_cnt
);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_CLEAR   = 2'd1,
      ST_RELEASE = 2'd2,
      ST_IDLE    = 2'd3
   } state_t;

   // Terminal counts, widened to the 16-bit counter so the compares use every counter bit.
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] CLR_LAST  = 16'(CLR_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic        viol_q;

   // State register and shared hold/clear counter; reset lands in HOLD so power-on runs a full clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_HOLD;
         cnt   <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: any violation sends the FSM to HOLD with a fresh count, even on the final clear word.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_HOLD: begin
            if (viol_i) begin
               cnt_nxt = 16'd0;
            end else if (cnt == HOLD_LAST) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         ST_CLEAR: begin
            if (viol_i) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = 16'd0;
            end else if (cnt == CLR_LAST) begin
               state_nxt = ST_RELEASE;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         ST_RELEASE: begin
            state_nxt = viol_i ? ST_HOLD : ST_IDLE;
            cnt_nxt   = 16'd0;
         end
         ST_IDLE: begin
            state_nxt = viol_i ? ST_HOLD : ST_IDLE;
            cnt_nxt   = 16'd0;
         end
         default: begin
            state_nxt = ST_HOLD;
            cnt_nxt   = 16'd0;
         end
      endcase
   end

   // Moore output decode from the state and counter registers only, so viol_i never reaches an output combinationally.
   always_comb begin
      cpu_rst      = 1'b1;
      clr_ram      = 1'b0;
      ram_clr_we   = 1'b0;
      ram_clr_addr = '0;
      busy         = 1'b1;
      case (state)
         ST_HOLD: begin
            cpu_rst = 1'b1;
         end
         ST_CLEAR: begin
            clr_ram      = 1'b1;
            ram_clr_we   = 1'b1;
            ram_clr_addr = cnt[RAM_AW-1:0];
         end
         ST_RELEASE: begin
            cpu_rst = 1'b1;
         end
         ST_IDLE: begin
            cpu_rst = 1'b0;
            busy    = 1'b0;
         end
         default: begin
            cpu_rst = 1'b1;
         end
      endcase
   end

   // Clearing always writes zeros.
   assign ram_clr_data = 16'h0000;

   // Violation edge counter, saturating at 8'hFF; the power-on sequence has no edge and is not counted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         viol_q   <= 1'b0;
         viol_cnt <= 8'd0;
      end else begin
         viol_q <= viol_i;
         if (viol_i && !viol_q && (viol_cnt != 8'hFF)) begin
            viol_cnt <= viol_cnt + 8'd1;
         end
      end
   end

endmodule
